multisim_apb_arbiter: RTL and testbench

MULTISIM_APB_ARBITER -- requirements
Module: multisim_apb_arbiter

---
 rtl/multisim_apb_pkg.sv | 37 +++
 rtl/multisim_apb_arbiter_if.sv | 32 +++
 rtl/multisim_rr_arbiter.sv | 36 +++
 rtl/multisim_apb_arbiter.sv | 119 +++++++++++
 tb/tb_multisim_apb_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multisim_apb_pkg.sv
// Shared APB types for the multisim push path: FSM states, default request/response structs, ring-index helper.
// Latency: none; types and pure functions only.
// Backpressure: none; no handshake lives here.
package multisim_apb_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;
    localparam int APB_SW = APB_DW / 8;

    // Downstream transfer phases, also used by the APB push client.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic [APB_AW-1:0] paddr;
        logic              pwrite;
        logic [APB_DW-1:0] pwdata;
        logic [APB_SW-1:0] pstrb;
        logic [2:0]        pprot;
    } msim_apb_req_t;

    typedef struct packed {
        logic [APB_DW-1:0] prdata;
        logic              pslverr;
    } msim_apb_resp_t;

    // (base + off) mod n, for base < n and off < n: one conditional subtract.
    function automatic int unsigned rr_wrap(int unsigned base, int unsigned off, int unsigned n);
        int unsigned s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/multisim_apb_arbiter_if.sv
// Bundle of the N upstream APB manager ports and the single downstream port of the arbiter.
// Latency: wires only.
// Backpressure: carried by the pready signals; slave = arbiter view, master = environment view.
interface multisim_apb_arbiter_if #(
    parameter int  N_PORTS = 2,
    parameter type req_t   = multisim_apb_pkg::msim_apb_req_t,
    parameter type resp_t  = multisim_apb_pkg::msim_apb_resp_t
);
    // upstream side
    req_t               i_apb_s_req [N_PORTS];
    logic [N_PORTS-1:0] i_apb_s_psel;
    logic [N_PORTS-1:0] i_apb_s_penable;
    resp_t              o_apb_s_resp [N_PORTS];
    logic [N_PORTS-1:0] o_apb_s_pready;
    // downstream side
    req_t               o_apb_m_req;
    logic               o_apb_m_psel;
    logic               o_apb_m_penable;
    resp_t              i_apb_m_resp;
    logic               i_apb_m_pready;

    modport slave (
        input  i_apb_s_req, i_apb_s_psel, i_apb_s_penable, i_apb_m_resp, i_apb_m_pready,
        output o_apb_s_resp, o_apb_s_pready, o_apb_m_req, o_apb_m_psel, o_apb_m_penable
    );

    modport master (
        output i_apb_s_req, i_apb_s_psel, i_apb_s_penable, i_apb_m_resp, i_apb_m_pready,
        input  o_apb_s_resp, o_apb_s_pready, o_apb_m_req, o_apb_m_psel, o_apb_m_penable
    );

endinterface

// File: rtl/multisim_rr_arbiter.sv
// Round-robin pick: first set request bit searching from ptr upward, wrapping at N_PORTS.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the pick.
module multisim_rr_arbiter
    import multisim_apb_pkg::*;
#(
    parameter int N_PORTS = 2
) (
    input  logic [N_PORTS-1:0]         req_vec,
    input  logic [$clog2(N_PORTS)-1:0] ptr,
    output logic [N_PORTS-1:0]         win_oh,
    output logic [$clog2(N_PORTS)-1:0] win_idx,
    output logic                       win_vld
);

    localparam int IDX_W = $clog2(N_PORTS);

    logic [IDX_W-1:0] cand;

    // Walk the ring from ptr; the first requester seen wins, later ones are ignored.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand = IDX_W'(rr_wrap(32'(ptr), i, N_PORTS));
            if (!win_vld && req_vec[cand]) begin
                win_vld       = 1'b1;
                win_oh[cand]  = 1'b1;
                win_idx       = cand;
            end
        end
    end

endmodule

// File: rtl/multisim_apb_arbiter.sv
// N-to-1 APB arbiter in front of the multisim push client; round-robin, one downstream transfer at a time.
// Latency: psel seen in IDLE at T -> SETUP at T+1, ACCESS from T+2; completion pready passes through combinationally.
// Backpressure: losing ports wait with pready=0; ACCESS holds until downstream pready, then one IDLE bubble.
module multisim_apb_arbiter
    import multisim_apb_pkg::*;
#(
    parameter int  N_PORTS    = 2,    // 2..16
    parameter type apb_req_t  = multisim_apb_pkg::msim_apb_req_t,
    parameter type apb_resp_t = multisim_apb_pkg::msim_apb_resp_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multisim_apb_arbiter_if.slave      bus,
    output logic [$clog2(N_PORTS)-1:0] o_grant_idx,
    output logic                       o_busy
);

    localparam int IDX_W = $clog2(N_PORTS);

    apb_state_t       state_q;
    apb_state_t       state_d;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [N_PORTS-1:0] win_oh;
    logic [IDX_W-1:0] win_idx;
    logic             win_vld;
    apb_req_t         m_req_sel;

    multisim_rr_arbiter #(
        .N_PORTS (N_PORTS)
    ) u_rr (
        .req_vec (bus.i_apb_s_psel),
        .ptr     (rr_ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant and pointer only move when a new transfer is accepted, so the grant stays locked through ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else if (state_q == IDLE && win_vld) begin
            grant_q  <= win_idx;
            rr_ptr_q <= IDX_W'(rr_wrap(32'(win_idx), 1, N_PORTS));
        end
    end

    // Next state: accept in IDLE, single SETUP cycle, hold ACCESS until downstream ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (bus.i_apb_m_pready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: downstream phase signals, request mux, and response/ready steering to the granted port.
    // A granted port that has dropped psel gets neither response nor ready (its response is discarded).
    always_comb begin
        bus.o_apb_m_psel    = 1'b0;
        bus.o_apb_m_penable = 1'b0;
        bus.o_apb_s_pready  = '0;
        m_req_sel           = apb_req_t'('0);
        for (int k = 0; k < N_PORTS; k++) begin
            bus.o_apb_s_resp[k] = apb_resp_t'('0);
        end
        case (state_q)
            SETUP: begin
                bus.o_apb_m_psel = 1'b1;
                m_req_sel        = bus.i_apb_s_req[grant_q];
            end
            ACCESS: begin
                bus.o_apb_m_psel    = 1'b1;
                bus.o_apb_m_penable = 1'b1;
                m_req_sel           = bus.i_apb_s_req[grant_q];
            end
            default: ;
        endcase
        for (int k = 0; k < N_PORTS; k++) begin
            if (state_q != IDLE && grant_q == IDX_W'(k) && bus.i_apb_s_psel[k]) begin
                bus.o_apb_s_resp[k]   = bus.i_apb_m_resp;
                bus.o_apb_s_pready[k] = (state_q == ACCESS) && bus.i_apb_m_pready;
            end
        end
        bus.o_apb_m_req = m_req_sel;
    end

    assign o_grant_idx = grant_q;
    assign o_busy      = (state_q != IDLE);

`ifndef SYNTHESIS
    // Protocol checks for simulation.
    a_pready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.o_apb_s_pready));
    a_setup_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == SETUP) |=> (state_q == ACCESS));
    a_m_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ACCESS && $past(state_q) != IDLE && bus.i_apb_s_psel[grant_q])
        |-> (bus.o_apb_m_req == $past(bus.o_apb_m_req)));
    a_penable_needs_psel: assert property (@(posedge clk) disable iff (!rst_n)
        ((bus.i_apb_s_penable & ~bus.i_apb_s_psel) == '0));
    a_pick_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        win_vld |-> ($onehot(win_oh) && win_oh[win_idx]));
`endif

endmodule

// File: tb/tb_multisim_apb_arbiter.sv
// Directed bench for multisim_apb_arbiter with a transaction-level reference model checked every cycle.
// Latency: model follows "grant, one setup cycle, access until ready" in cycle counts.
// Backpressure: downstream pready driven directly by the stimulus.
module tb_multisim_apb_arbiter;
    import multisim_apb_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] grant_idx;
    logic busy;

    int total = 0;
    int bad   = 0;

    multisim_apb_arbiter_if #(
        .N_PORTS (N),
        .req_t   (msim_apb_req_t),
        .resp_t  (msim_apb_resp_t)
    ) bus ();

    multisim_apb_arbiter #(
        .N_PORTS    (N),
        .apb_req_t  (msim_apb_req_t),
        .apb_resp_t (msim_apb_resp_t)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_grant_idx (grant_idx),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A transfer is "active" from the cycle after it is accepted; age 0 is the setup cycle.
    bit mdl_active = 1'b0;
    int mdl_port   = 0;
    int mdl_age    = 0;
    int mdl_ptr    = 0;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            int c = (p + i) % N;
            if (v[c]) return c;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_active <= 1'b0;
            mdl_port   <= 0;
            mdl_age    <= 0;
            mdl_ptr    <= 0;
        end else if (!mdl_active) begin
            if (bus.i_apb_s_psel != '0) begin
                mdl_active <= 1'b1;
                mdl_port   <= pick(bus.i_apb_s_psel, mdl_ptr);
                mdl_ptr    <= (pick(bus.i_apb_s_psel, mdl_ptr) + 1) % N;
                mdl_age    <= 0;
            end
        end else if (mdl_age == 0) begin
            mdl_age <= 1;
        end else if (bus.i_apb_m_pready) begin
            mdl_active <= 1'b0;
        end else begin
            mdl_age <= mdl_age + 1;
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        logic           e_pen;
        logic [N-1:0]   e_rdy;
        msim_apb_req_t  e_req;
        msim_apb_resp_t e_resp;
        e_pen = mdl_active && (mdl_age >= 1);
        e_req = mdl_active ? bus.i_apb_s_req[mdl_port] : '0;
        e_rdy = '0;
        chk("m_psel", 80'(bus.o_apb_m_psel), 80'(mdl_active));
        chk("m_penable", 80'(bus.o_apb_m_penable), 80'(e_pen));
        chk("m_req", 80'(bus.o_apb_m_req), 80'(e_req));
        chk("grant_idx", 80'(grant_idx), 80'(mdl_port));
        chk("busy", 80'(busy), 80'(mdl_active));
        for (int k = 0; k < N; k++) begin
            e_resp = (mdl_active && mdl_port == k && bus.i_apb_s_psel[k]) ? bus.i_apb_m_resp : '0;
            e_rdy[k] = e_pen && mdl_port == k && bus.i_apb_m_pready && bus.i_apb_s_psel[k];
            chk($sformatf("s_resp%0d", k), 80'(bus.o_apb_s_resp[k]), 80'(e_resp));
        end
        chk("s_pready", 80'(bus.o_apb_s_pready), 80'(e_rdy));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic w, input logic [31:0] d);
        msim_apb_req_t r;
        r.paddr  = a;
        r.pwrite = w;
        r.pwdata = d;
        r.pstrb  = 4'hF;
        r.pprot  = 3'b000;
        bus.i_apb_s_req[k] = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        msim_apb_resp_t rr;
        for (int k = 0; k < N; k++) set_req(k, 32'h0, 1'b0, 32'h0);
        bus.i_apb_s_psel    = '0;
        bus.i_apb_s_penable = '0;
        bus.i_apb_m_resp    = '0;
        bus.i_apb_m_pready  = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 80'(busy), 80'(0));
        chk("rst_grant", 80'(grant_idx), 80'(0));
        chk("rst_m_psel", 80'(bus.o_apb_m_psel), 80'(0));
        step();
        rst_n = 1'b1;

        // single write from port 0, ready at first ACCESS cycle
        set_req(0, 32'h10, 1'b1, 32'hA5);
        bus.i_apb_s_psel   = 4'b0001;
        bus.i_apb_m_pready = 1'b1;
        @(negedge clk);
        chk("s1_idle_busy", 80'(busy), 80'(0));
        step();
        bus.i_apb_s_penable = 4'b0001;
        @(negedge clk);
        chk("s1_setup_psel", 80'(bus.o_apb_m_psel), 80'(1));
        chk("s1_setup_pen", 80'(bus.o_apb_m_penable), 80'(0));
        chk("s1_paddr", 80'(bus.o_apb_m_req.paddr), 80'(32'h10));
        chk("s1_pwdata", 80'(bus.o_apb_m_req.pwdata), 80'(32'hA5));
        step();
        @(negedge clk);
        chk("s1_pready", 80'(bus.o_apb_s_pready), 80'(4'b0001));
        step();
        bus.i_apb_s_psel    = '0;
        bus.i_apb_s_penable = '0;
        @(negedge clk);
        chk("s1_done_busy", 80'(busy), 80'(0));

        // reset pulse while idle brings the pointer back to port 0
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // all four ports request together: 0,1,2,3 then back to 0
        for (int k = 0; k < N; k++) set_req(k, 32'h100 + 32'(k), 1'b1, 32'h1000 + 32'(k));
        bus.i_apb_s_psel    = 4'b1111;
        bus.i_apb_s_penable = 4'b1111;
        bus.i_apb_m_pready  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            chk($sformatf("s2_grant%0d", i), 80'(grant_idx), 80'(order[i]));
            chk($sformatf("s2_paddr%0d", i), 80'(bus.o_apb_m_req.paddr), 80'(32'h100 + 32'(order[i])));
            step();
            step();
        end

        // port 1 waits five ACCESS cycles; port 0 joins mid-wait and is served next
        bus.i_apb_s_psel    = 4'b0010;
        bus.i_apb_s_penable = 4'b0000;
        bus.i_apb_m_pready  = 1'b0;
        step();
        bus.i_apb_s_penable = 4'b0010;
        @(negedge clk);
        chk("s3_setup_grant", 80'(grant_idx), 80'(1));
        for (int a = 1; a <= 5; a++) begin
            step();
            if (a == 2) begin
                bus.i_apb_s_psel    = 4'b0011;
                bus.i_apb_s_penable = 4'b0011;
            end
            if (a == 5) bus.i_apb_m_pready = 1'b1;
            @(negedge clk);
            chk($sformatf("s3_wait_rdy%0d", a), 80'(bus.o_apb_s_pready), 80'((a == 5) ? 4'b0010 : 4'b0000));
            chk($sformatf("s3_wait_grant%0d", a), 80'(grant_idx), 80'(1));
        end
        step();
        bus.i_apb_s_psel    = 4'b0001;
        bus.i_apb_s_penable = 4'b0001;
        @(negedge clk);
        chk("s3_bubble", 80'(busy), 80'(0));
        step();
        @(negedge clk);
        chk("s3_next_grant", 80'(grant_idx), 80'(0));
        step();
        @(negedge clk);
        chk("s3_p0_rdy", 80'(bus.o_apb_s_pready), 80'(4'b0001));
        step();
        bus.i_apb_s_psel    = '0;
        bus.i_apb_s_penable = '0;

        // read from port 1 with error response
        set_req(1, 32'h20, 1'b0, 32'h0);
        bus.i_apb_s_psel = 4'b0010;
        rr.prdata  = 32'hDEADBEEF;
        rr.pslverr = 1'b1;
        bus.i_apb_m_resp   = rr;
        bus.i_apb_m_pready = 1'b1;
        step();
        bus.i_apb_s_penable = 4'b0010;
        step();
        @(negedge clk);
        chk("s4_resp1", 80'(bus.o_apb_s_resp[1]), 80'({32'hDEADBEEF, 1'b1}));
        chk("s4_resp0", 80'(bus.o_apb_s_resp[0]), 80'(0));
        chk("s4_rdy", 80'(bus.o_apb_s_pready), 80'(4'b0010));
        step();
        bus.i_apb_s_psel    = '0;
        bus.i_apb_s_penable = '0;
        bus.i_apb_m_resp    = '0;

        // port 0 abandons its transfer during ACCESS
        bus.i_apb_s_psel   = 4'b0001;
        bus.i_apb_m_pready = 1'b0;
        step();
        bus.i_apb_s_penable = 4'b0001;
        @(negedge clk);
        chk("s5_grant", 80'(grant_idx), 80'(0));
        step();
        step();
        bus.i_apb_s_psel    = '0;
        bus.i_apb_s_penable = '0;
        bus.i_apb_m_pready  = 1'b1;
        @(negedge clk);
        chk("s5_no_rdy", 80'(bus.o_apb_s_pready), 80'(0));
        chk("s5_still_access", 80'(bus.o_apb_m_penable), 80'(1));
        step();
        @(negedge clk);
        chk("s5_idle", 80'(busy), 80'(0));

        // reset in the middle of an ACCESS from port 2
        step();
        bus.i_apb_s_psel   = 4'b0100;
        bus.i_apb_m_pready = 1'b0;
        step();
        bus.i_apb_s_penable = 4'b0100;
        step();
        @(negedge clk);
        chk("s6_access_grant", 80'(grant_idx), 80'(2));
        #2;
        rst_n = 1'b0;
        bus.i_apb_m_pready = 1'b1;
        #1;
        chk("s6_rst_psel", 80'(bus.o_apb_m_psel), 80'(0));
        chk("s6_rst_pen", 80'(bus.o_apb_m_penable), 80'(0));
        chk("s6_rst_busy", 80'(busy), 80'(0));
        chk("s6_rst_grant", 80'(grant_idx), 80'(0));
        chk("s6_rst_rdy", 80'(bus.o_apb_s_pready), 80'(0));
        chk("s6_rst_req", 80'(bus.o_apb_m_req), 80'(0));
        bus.i_apb_s_psel    = '0;
        bus.i_apb_s_penable = '0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("s6_quiet_rdy%0d", i), 80'(bus.o_apb_s_pready), 80'(0));
            chk($sformatf("s6_quiet_busy%0d", i), 80'(busy), 80'(0));
            step();
        end
        // pointer is 0 again: of ports 1 and 3, port 1 comes first
        bus.i_apb_s_psel = 4'b1010;
        step();
        @(negedge clk);
        chk("s6_ptr_reset", 80'(grant_idx), 80'(1));
        step();
        step();
        bus.i_apb_s_psel = '0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
